// File: rtl/cdf_controller_if.sv
// CDF controller control interface.
// Groups the start/abort requests with the datapath strobes and status.
interface cdf_controller_if;
    logic       start;
    logic       abort;
    logic       read_first_value;
    logic       scratch_mem_read_ready;
    logic       cdf_computation_done;
    logic       read_next_value;
    logic       cdf_done;
    logic       busy;
    logic       done;
    logic [5:0] iter_count;

    modport master (
        output start,
        output abort,
        input  read_first_value,
        input  scratch_mem_read_ready,
        input  cdf_computation_done,
        input  read_next_value,
        input  cdf_done,
        input  busy,
        input  done,
        input  iter_count
    );

    modport slave (
        input  start,
        input  abort,
        output read_first_value,
        output scratch_mem_read_ready,
        output cdf_computation_done,
        output read_next_value,
        output cdf_done,
        output busy,
        output done,
        output iter_count
    );
endinterface

// File: rtl/cdf_controller.sv
// CDF pass sequencer: walks histogram read pairs and strobes the datapath.
// Outputs decode from the state register only, so no input reaches an output.
module cdf_controller #(
    parameter int NUM_ITER     = 32,
    parameter int READ_LATENCY = 2
) (
    input logic             clk,
    input logic             reset,
    cdf_controller_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FIRST   = 3'd1,
        READ    = 3'd2,
        COMPUTE = 3'd3,
        WRITE   = 3'd4,
        NEXT    = 3'd5,
        FINAL   = 3'd6,
        DONE    = 3'd7
    } state_t;

    localparam logic [2:0] RL_LOAD   = 3'(READ_LATENCY - 1);
    localparam logic [5:0] LAST_ITER = 6'(NUM_ITER - 1);

    state_t     state;
    state_t     state_nxt;
    logic [2:0] wait_cnt;
    logic [2:0] wait_nxt;
    logic [5:0] iter;
    logic [5:0] iter_nxt;

    // State, wait counter and iteration index registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            wait_cnt <= '0;
            iter     <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_nxt;
            iter     <= iter_nxt;
        end
    end

    // Next-state sequencing; abort overrides every transition
    always_comb begin
        state_nxt = state;
        wait_nxt  = wait_cnt;
        iter_nxt  = iter;
        if (bus.abort) begin
            state_nxt = IDLE;
            wait_nxt  = '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        state_nxt = FIRST;
                        iter_nxt  = '0;
                    end
                end
                FIRST: begin
                    state_nxt = READ;
                    wait_nxt  = RL_LOAD;
                end
                READ: begin
                    if (wait_cnt == 3'd0) begin
                        state_nxt = COMPUTE;
                    end else begin
                        wait_nxt = wait_cnt - 3'd1;
                    end
                end
                COMPUTE: begin
                    state_nxt = WRITE;
                    wait_nxt  = 3'd1;
                end
                WRITE: begin
                    if (wait_cnt == 3'd0) begin
                        state_nxt = (iter == LAST_ITER) ? FINAL : NEXT;
                    end else begin
                        wait_nxt = wait_cnt - 3'd1;
                    end
                end
                NEXT: begin
                    state_nxt = READ;
                    wait_nxt  = RL_LOAD;
                    iter_nxt  = iter + 6'd1;
                end
                FINAL: begin
                    state_nxt = DONE;
                end
                DONE: begin
                    state_nxt = IDLE;
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    assign bus.read_first_value       = (state == FIRST);
    assign bus.scratch_mem_read_ready = (state == COMPUTE);
    assign bus.cdf_computation_done   = (state == WRITE);
    assign bus.read_next_value        = (state == NEXT);
    assign bus.cdf_done               = (state == FINAL);
    assign bus.done                   = (state == DONE);
    assign bus.busy                   = (state != IDLE);
    assign bus.iter_count             = iter;

endmodule
